// File: rtl/bp_cce_pending_wr_arb_pkg.sv
// Shared types and helpers for the pending-bit write arbiter.
`ifndef BP_CCE_PENDING_WR_ARB_PKG_SV
`define BP_CCE_PENDING_WR_ARB_PKG_SV

// Queued memory-side write: line address plus increment/decrement flag.
`define BP_DECLARE_CCE_PENDING_WR_ENTRY_S(paddr_width_mp, addr_offset_mp) \
   typedef struct packed { \
      logic [paddr_width_mp-addr_offset_mp-1:0] line_addr; \
      logic                                     pending; \
   } bp_cce_pending_wr_entry_s

package bp_cce_pending_wr_arb_pkg;

   // Which source owns the pending-bit write port this cycle.
   typedef enum logic [1:0] {
      e_wr_src_none  = 2'b00,
      e_wr_src_ucode = 2'b01,
      e_wr_src_mem   = 2'b10
   } wr_src_e;

   // clog2 that never returns 0, so a width derived from it is always legal.
   function automatic int safe_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

`endif

// File: rtl/bp_cce_pending_wr_arb_if.sv
// Memory-side write channel (valid/ready) into the pending-bit arbiter.
interface bp_cce_pending_wr_arb_if #(
   parameter int paddr_width_p = 40
);
   logic                     mem_w_v;
   logic                     mem_w_ready_and;
   logic [paddr_width_p-1:0] mem_w_addr;
   logic                     mem_pending;

   modport master (
      output mem_w_v,
      output mem_w_addr,
      output mem_pending,
      input  mem_w_ready_and
   );

   modport slave (
      input  mem_w_v,
      input  mem_w_addr,
      input  mem_pending,
      output mem_w_ready_and
   );
endinterface

// File: rtl/bp_cce_pending_wr_arb_fifo.sv
// Circular buffer of memory-side pending writes with per-entry line compare.
module bp_cce_pending_wr_arb_fifo
   import bp_cce_pending_wr_arb_pkg::*;
#(
   parameter  int paddr_width_p = 40,
   parameter  int addr_offset_p = 6,
   parameter  int els_p         = 4,
   localparam int line_width_lp = paddr_width_p - addr_offset_p,
   localparam int lg_els_lp     = safe_clog2(els_p + 1),
   localparam int ptr_width_lp  = safe_clog2(els_p)
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     enq_i,
   input  logic [line_width_lp-1:0] enq_line_i,
   input  logic                     enq_pending_i,
   input  logic                     deq_i,
   input  logic [line_width_lp-1:0] check_line_i,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [line_width_lp-1:0] head_line_o,
   output logic                     head_pending_o,
   output logic                     hit_o
);

   `BP_DECLARE_CCE_PENDING_WR_ENTRY_S(paddr_width_p, addr_offset_p);

   localparam logic [ptr_width_lp-1:0] last_ptr_lp   = ptr_width_lp'(els_p - 1);
   localparam logic [lg_els_lp-1:0]    full_count_lp = lg_els_lp'(els_p);

   bp_cce_pending_wr_entry_s [els_p-1:0] mem_q;
   bp_cce_pending_wr_entry_s             enq_entry;
   logic [els_p-1:0]                     valid_q, valid_d;
   logic [els_p-1:0]                     match;
   logic [ptr_width_lp-1:0]              head_q, head_d, tail_q, tail_d;
   logic [lg_els_lp-1:0]                 count_q, count_d;

   assign enq_entry.line_addr = enq_line_i;
   assign enq_entry.pending   = enq_pending_i;

   // Next-state for pointers, occupancy and the per-slot valid window.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      valid_d = valid_q;
      if (deq_i) begin
         head_d          = (head_q == last_ptr_lp) ? '0 : head_q + ptr_width_lp'(1);
         valid_d[head_q] = 1'b0;
      end
      if (enq_i) begin
         tail_d          = (tail_q == last_ptr_lp) ? '0 : tail_q + ptr_width_lp'(1);
         valid_d[tail_q] = 1'b1;
      end
      case ({enq_i, deq_i})
         2'b10:   count_d = count_q + lg_els_lp'(1);
         2'b01:   count_d = count_q - lg_els_lp'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state; reset discards everything queued.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   // Entry storage; contents are only meaningful where valid_q is set.
   always_ff @(posedge clk_i) begin
      if (enq_i) begin
         mem_q[tail_q] <= enq_entry;
      end
   end

   // Hit only on occupied slots; the head being popped this cycle still counts.
   for (genvar i = 0; i < els_p; i++) begin : g_match
      assign match[i] = valid_q[i] & (mem_q[i].line_addr == check_line_i);
   end

   assign hit_o          = |match;
   assign full_o         = (count_q == full_count_lp);
   assign empty_o        = (count_q == '0);
   assign head_line_o    = mem_q[head_q].line_addr;
   assign head_pending_o = mem_q[head_q].pending;

`ifndef SYNTHESIS
   a_count_bound: assert property (@(posedge clk_i) count_q <= full_count_lp);
`endif

endmodule

// File: rtl/bp_cce_pending_wr_arb.sv
// Single-port feeder for the CCE pending-bit counters: microcode writes win,
// memory-side writes are queued and drained in order on idle microcode cycles.
module bp_cce_pending_wr_arb
   import bp_cce_pending_wr_arb_pkg::*;
#(
   parameter  int paddr_width_p = 40,
   parameter  int addr_offset_p = 6,
   parameter  int els_p         = 4,
   localparam int line_width_lp = paddr_width_p - addr_offset_p
) (
   input  logic                     clk_i,
   input  logic                     reset_i,

   input  logic                     ucode_w_v_i,
   input  logic [paddr_width_p-1:0] ucode_w_addr_i,
   input  logic                     ucode_w_addr_bypass_hash_i,
   input  logic                     ucode_pending_i,
   input  logic                     ucode_clear_i,

   bp_cce_pending_wr_arb_if.slave   mem_if,

   output logic                     w_v_o,
   output logic [paddr_width_p-1:0] w_addr_o,
   output logic                     w_addr_bypass_hash_o,
   output logic                     pending_o,
   output logic                     clear_o,

   input  logic [paddr_width_p-1:0] r_addr_i,
   output logic                     queue_hit_o,
   output logic                     empty_o
);

   logic                     fifo_full, fifo_empty;
   logic                     enq, deq;
   logic [line_width_lp-1:0] head_line;
   logic                     head_pending;
   wr_src_e                  wr_src;
   logic                     unused_r_addr_offset;

   // Block-offset bits of the lookup address play no part in the line compare.
   assign unused_r_addr_offset = ^r_addr_i[addr_offset_p-1:0];

   // Ready looks only at registered occupancy, so a full queue refuses even
   // when it is also draining this cycle.
   assign mem_if.mem_w_ready_and = ~reset_i & ~fifo_full;
   assign enq                    = mem_if.mem_w_v & mem_if.mem_w_ready_and;
   assign deq                    = (wr_src == e_wr_src_mem);
   assign empty_o                = fifo_empty;

   bp_cce_pending_wr_arb_fifo #(
      .paddr_width_p (paddr_width_p),
      .addr_offset_p (addr_offset_p),
      .els_p         (els_p)
   ) u_fifo (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .enq_i          (enq),
      .enq_line_i     (mem_if.mem_w_addr[paddr_width_p-1:addr_offset_p]),
      .enq_pending_i  (mem_if.mem_pending),
      .deq_i          (deq),
      .check_line_i   (r_addr_i[paddr_width_p-1:addr_offset_p]),
      .full_o         (fifo_full),
      .empty_o        (fifo_empty),
      .head_line_o    (head_line),
      .head_pending_o (head_pending),
      .hit_o          (queue_hit_o)
   );

   // Pick the write-port owner: microcode first, then the queue head.
   always_comb begin
      wr_src = e_wr_src_none;
      if (ucode_w_v_i) begin
         wr_src = e_wr_src_ucode;
      end else if (~fifo_empty) begin
         wr_src = e_wr_src_mem;
      end
   end

   // Drive the pending-bit write port from the selected source.
   always_comb begin
      w_v_o                = 1'b0;
      w_addr_o             = '0;
      w_addr_bypass_hash_o = 1'b0;
      pending_o            = 1'b0;
      clear_o              = 1'b0;
      case (wr_src)
         e_wr_src_ucode: begin
            w_v_o                = 1'b1;
            w_addr_o             = ucode_w_addr_i;
            w_addr_bypass_hash_o = ucode_w_addr_bypass_hash_i;
            pending_o            = ucode_pending_i;
            clear_o              = ucode_clear_i;
         end
         e_wr_src_mem: begin
            w_v_o     = 1'b1;
            w_addr_o  = {head_line, {addr_offset_p{1'b0}}};
            pending_o = head_pending;
         end
         default: begin
            w_v_o = 1'b0;
         end
      endcase
   end

`ifndef SYNTHESIS
   a_mem_v_held: assert property (@(posedge clk_i) disable iff (reset_i)
      (mem_if.mem_w_v & ~mem_if.mem_w_ready_and) |=> mem_if.mem_w_v);
`endif

endmodule
